// File: rtl/load_store_unit.sv
// Data-memory access stage: one outstanding load/store, write-back pulse on load.
// Optional busy-timeout abort is enabled by defining LSU_TIMEOUT_EN.
package simple_processor_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
endpackage

module load_store_unit #(
    parameter int ADDR_WIDTH     = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_rd_addr_i,
    output logic                  req_ready_o,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                  dmem_ack_i,
    output logic                  wb_valid_o,
    output logic [2:0]            wb_rd_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_we;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [2:0]              r_rd;
    logic [DATA_WIDTH-1:0]   r_wb_data;
    logic [2:0]              r_wb_rd;
    logic                    w_idle;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_accept;
    logic                    w_timeout;

    assign w_idle   = (r_state == S_IDLE);
    assign w_busy   = (r_state == S_BUSY);
    assign w_done   = (r_state == S_DONE);
    assign w_accept = w_idle & req_valid_i;

`ifdef LSU_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Ack in the expiry cycle takes priority over the abort.
    assign w_timeout = w_busy & ~dmem_ack_i &
                       (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_busy && !dmem_ack_i) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dmem_ack_i || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_wb_rd   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_rd    <= req_rd_addr_i;
                r_err   <= 1'b0;
            end
            if (w_busy && dmem_ack_i && !r_we) begin
                r_wb_data <= dmem_rdata_i;
                r_wb_rd   <= r_rd;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready_o  = w_idle;
    assign stall_o      = w_busy | w_accept;
    assign dmem_req_o   = w_busy;
    assign dmem_we_o    = w_busy & r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_wdata_o = r_wdata;
    assign wb_valid_o   = w_done & ~r_we & ~r_err;
    assign wb_rd_addr_o = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign err_o        = w_done & r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: write-backs and stores are
// predicted when issued and checked when the DUT produces them.
module tb_load_store_unit;

    localparam int AW = simple_processor_pkg::ADDR_WIDTH;
    localparam int DW = simple_processor_pkg::DATA_WIDTH;

    typedef struct {
        logic [2:0]    rd;
        logic [DW-1:0] data;
    } wb_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [2:0]    req_rd_addr_i;
    logic          req_ready_o;
    logic          stall_o;
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [DW-1:0] dmem_wdata_o;
    logic [DW-1:0] dmem_rdata_i;
    logic          dmem_ack_i;
    logic          wb_valid_o;
    logic [2:0]    wb_rd_addr_o;
    logic [DW-1:0] wb_data_o;
    logic          err_o;

    int            n_cmp = 0;
    int            n_bad = 0;
    wb_exp_t       wb_q[$];
    st_exp_t       st_q[$];
    logic [DW-1:0] last_wb = '0;

    load_store_unit #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_addr_i(req_rd_addr_i),
        .req_ready_o  (req_ready_o),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_addr_o (wb_rd_addr_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && wb_valid_o === 1'b1) begin
            n_cmp++;
            if (wb_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: rd=%0d data=%h expected none",
                         wb_rd_addr_o, wb_data_o);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                if (wb_rd_addr_o !== e.rd || wb_data_o !== e.data) begin
                    n_bad++;
                    $display("FAIL wb_data: got rd=%0d data=%h want rd=%0d data=%h",
                             wb_rd_addr_o, wb_data_o, e.rd, e.data);
                end
            end
        end
        if (rst_i === 1'b0 && dmem_req_o === 1'b1 &&
            dmem_ack_i === 1'b1 && dmem_we_o === 1'b1) begin
            n_cmp++;
            if (st_q.size() == 0) begin
                n_bad++;
                $display("FAIL st_unexpected: addr=%h data=%h expected none",
                         dmem_addr_o, dmem_wdata_o);
            end else begin
                st_exp_t s;
                s = st_q.pop_front();
                if (dmem_addr_o !== s.addr || dmem_wdata_o !== s.data) begin
                    n_bad++;
                    $display("FAIL st_data: got addr=%h data=%h want addr=%h data=%h",
                             dmem_addr_o, dmem_wdata_o, s.addr, s.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [2:0] rd,
                          input int wait_n, input logic [DW-1:0] rdata);
        req_valid_i   = 1'b1;
        req_we_i      = we;
        req_addr_i    = addr;
        req_wdata_i   = wdata;
        req_rd_addr_i = rd;
        if (we) begin
            st_q.push_back('{addr, wdata});
        end else begin
            wb_q.push_back('{rd, rdata});
        end
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_accept: ready=%b stall=%b want 1 1",
                     req_ready_o, stall_o);
        end
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = ~addr;
        req_wdata_i = ~wdata;
        req_we_i    = ~we;
        for (int i = 1; i <= wait_n; i++) begin
            dmem_ack_i   = (i == wait_n);
            dmem_rdata_i = (i == wait_n) ? rdata : DW'($urandom);
            @(negedge clk_i);
            n_cmp++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== we ||
                dmem_addr_o !== addr || dmem_wdata_o !== wdata ||
                stall_o !== 1'b1 || req_ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_cyc%0d: req=%b we=%b a=%h d=%h st=%b rdy=%b want 1 %b %h %h 1 0",
                         i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
                         stall_o, req_ready_o, we, addr, wdata);
            end
            tick();
        end
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (wb_valid_o !== ~we || err_o !== 1'b0 || stall_o !== 1'b0 ||
            dmem_req_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL done: wbv=%b err=%b st=%b req=%b rdy=%b want %b 0 0 0 0",
                     wb_valid_o, err_o, stall_o, dmem_req_o, req_ready_o, ~we);
        end
        if (we) begin
            n_cmp++;
            if (wb_data_o !== last_wb) begin
                n_bad++;
                $display("FAIL wb_hold: got %h want %h", wb_data_o, last_wb);
            end
        end else begin
            last_wb = rdata;
        end
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL back_idle: ready=%b wbv=%b want 1 0",
                     req_ready_o, wb_valid_o);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_i         = 1'b1;
        req_valid_i   = 1'b0;
        req_we_i      = 1'b0;
        req_addr_i    = '0;
        req_wdata_i   = '0;
        req_rd_addr_i = '0;
        dmem_rdata_i  = '0;
        dmem_ack_i    = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || stall_o !== 1'b0 ||
            dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0 ||
            wb_valid_o !== 1'b0 || err_o !== 1'b0 ||
            dmem_addr_o !== '0 || dmem_wdata_o !== '0 ||
            wb_rd_addr_o !== '0 || wb_data_o !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: rdy=%b st=%b req=%b we=%b wbv=%b err=%b a=%h d=%h rd=%0d wd=%h",
                     req_ready_o, stall_o, dmem_req_o, dmem_we_o, wb_valid_o,
                     err_o, dmem_addr_o, dmem_wdata_o, wb_rd_addr_o, wb_data_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
        req_valid_i   = 1'b1;
        req_addr_i    = 16'h0044;
        req_rd_addr_i = 3'd6;
        tick();
        req_valid_i = 1'b0;
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (dmem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_prep: dmem_req=%b want 1", dmem_req_o);
        end
        tick();
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (dmem_req_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: req=%b ready=%b want 0 1",
                     dmem_req_o, req_ready_o);
        end
        tick();
        rst_i        = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (wb_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
                n_bad++;
                $display("FAIL late_ack%0d: wbv=%b ready=%b want 0 1",
                         i, wb_valid_o, req_ready_o);
            end
            tick();
        end
        dmem_ack_i = 1'b0;
    endtask

    task automatic test_load_zero_wait();
        do_req(1'b0, 16'h0010, 16'h0000, 3'd3, 1, 16'hBEEF);
        do_req(1'b0, 16'hFFFE, 16'h0000, 3'd7, 2, 16'h0001);
    endtask

    task automatic test_store_wait();
        do_req(1'b1, 16'h0020, 16'h1234, 3'd5, 4, 16'h5555);
    endtask

    task automatic test_back_to_back();
        req_valid_i   = 1'b1;
        req_we_i      = 1'b0;
        req_addr_i    = 16'h0100;
        req_rd_addr_i = 3'd1;
        wb_q.push_back('{3'd1, 16'hC0DE});
        tick();
        req_addr_i    = 16'h0200;
        req_rd_addr_i = 3'd2;
        dmem_ack_i    = 1'b1;
        dmem_rdata_i  = 16'hC0DE;
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b0 || dmem_addr_o !== 16'h0100) begin
            n_bad++;
            $display("FAIL b2b_busy1: ready=%b addr=%h want 0 0100",
                     req_ready_o, dmem_addr_o);
        end
        tick();
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b0 || stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done: ready=%b stall=%b want 0 0",
                     req_ready_o, stall_o);
        end
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: ready=%b stall=%b req=%b want 1 1 0",
                     req_ready_o, stall_o, dmem_req_o);
        end
        wb_q.push_back('{3'd2, 16'h7777});
        tick();
        req_valid_i  = 1'b0;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'h7777;
        @(negedge clk_i);
        n_cmp++;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== 16'h0200) begin
            n_bad++;
            $display("FAIL b2b_busy2: req=%b addr=%h want 1 0200",
                     dmem_req_o, dmem_addr_o);
        end
        tick();
        dmem_ack_i = 1'b0;
        last_wb    = 16'h7777;
        tick();
        tick();
    endtask

    task automatic test_spurious_ack();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'h9999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (req_ready_o !== 1'b1 || dmem_req_o !== 1'b0 ||
                wb_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL spur_idle%0d: rdy=%b req=%b wbv=%b want 1 0 0",
                         i, req_ready_o, dmem_req_o, wb_valid_o);
            end
            tick();
        end
        req_valid_i   = 1'b1;
        req_we_i      = 1'b0;
        req_addr_i    = 16'h0300;
        req_rd_addr_i = 3'd4;
        wb_q.push_back('{3'd4, 16'h9999});
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (req_ready_o !== 1'b1 || wb_valid_o !== 1'b0 ||
                wb_data_o !== 16'h9999) begin
                n_bad++;
                $display("FAIL spur_after%0d: rdy=%b wbv=%b wd=%h want 1 0 9999",
                         i, req_ready_o, wb_valid_o, wb_data_o);
            end
            tick();
        end
        dmem_ack_i = 1'b0;
        last_wb    = 16'h9999;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n             = 0;
        req_valid_i   = 1'b1;
        req_we_i      = 1'b0;
        req_addr_i    = 16'h0400;
        req_rd_addr_i = 3'd2;
        tick();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        while (dmem_req_o === 1'b1 && n < 40) begin
            n++;
            tick();
            @(negedge clk_i);
        end
        n_cmp++;
        if (n != 8 || err_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: req_cycles=%0d err=%b wbv=%b want 8 1 0",
                     n, err_o, wb_valid_o);
        end
        tick();
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_idle: ready=%b err=%b want 1 0",
                     req_ready_o, err_o);
        end
        tick();
        do_req(1'b0, 16'h0404, 16'h0000, 3'd5, 8, 16'h4321);
    endtask
`endif

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_back_to_back();
        test_spurious_ack();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        n_cmp++;
        if (wb_q.size() != 0 || st_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: wb_left=%0d st_left=%0d want 0 0",
                     wb_q.size(), st_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the simple processor; sits directly downstream of the execution block and owns the `dmem_*` bus. It accepts one load or store per transaction from the execution stage. It drives a single-outstanding request/ack handshake to data memory and stalls the front end until the access completes. Load results are returned as a one-cycle write-back pulse to the register file.

## Interface
Parameters:
- `ADDR_WIDTH`, default `simple_processor_pkg::ADDR_WIDTH`: data address bus width.
- `DATA_WIDTH`, default `simple_processor_pkg::DATA_WIDTH`: data bus width.
- `TIMEOUT_CYCLES`, default 255: cycles in BUSY before abort. Used only with `LSU_TIMEOUT_EN`; legal range 1..65535.

Ports:
- `clk_i`, in, 1: single global clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_valid_i`, in, 1: execution stage presents a memory operation.
- `req_we_i`, in, 1: 1 = store, 0 = load.
- `req_addr_i`, in, `ADDR_WIDTH`: effective address.
- `req_wdata_i`, in, `DATA_WIDTH`: store data.
- `req_rd_addr_i`, in, 3: load destination register.
- `req_ready_o`, out, 1: LSU can accept; high only in IDLE.
- `stall_o`, out, 1: hold PC and decode.
- `dmem_req_o`, out, 1: active data request.
- `dmem_we_o`, out, 1: write request.
- `dmem_addr_o`, out, `ADDR_WIDTH`: data address.
- `dmem_wdata_o`, out, `DATA_WIDTH`: write data.
- `dmem_rdata_i`, in, `DATA_WIDTH`: read data, valid when `dmem_ack_i` is high.
- `dmem_ack_i`, in, 1: request completed.
- `wb_valid_o`, out, 1: load result valid, one-cycle pulse.
- `wb_rd_addr_o`, out, 3: write-back register address.
- `wb_data_o`, out, `DATA_WIDTH`: load data.
- `err_o`, out, 1: timeout abort pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `req_valid_i` is high, latch `we`, `addr`, `wdata` and `rd` into internal registers, then go to BUSY.
  - A request is accepted only when `req_valid_i & req_ready_o`.
- **BUSY**
  - `dmem_req_o` = 1. `dmem_we_o`, `dmem_addr_o` and `dmem_wdata_o` come from registers and stay stable for the whole of BUSY.
  - When `dmem_ack_i` = 1, go to DONE. For a load, also capture `dmem_rdata_i` into `wb_data_o`.
- **DONE**, exactly one cycle:
  - `wb_valid_o` = ~latched `we`, so stores never pulse write-back.
  - Next state is IDLE.
  - `req_valid_i` is ignored in DONE.
- `dmem_ack_i` is ignored in IDLE and DONE.
- The address passes through unmodified; no alignment check.
- `stall_o` = (state == BUSY) | (state == IDLE & `req_valid_i`).
  - Combinational.
  - Deasserts in DONE so the pipeline advances one cycle after ack.
- `wb_rd_addr_o` and `wb_data_o` hold their last value outside DONE.

## Timing
- **Reset:** `rst_i` high at a rising edge gives, at that edge:
  - state = IDLE;
  - `dmem_req_o`, `dmem_we_o`, `wb_valid_o` and `err_o` = 0;
  - `dmem_addr_o`, `dmem_wdata_o`, `wb_rd_addr_o` and `wb_data_o` = 0;
  - timeout counter = 0.
- **Reset mid-operation:** the request is dropped at the edge and a late ack is ignored.
- **Latency:** accept at edge 0; `dmem_req_o` high from cycle 1; ack sampled at edge k (k ≥ 1); `wb_valid_o` high in cycle k+1; `req_ready_o` high in cycle k+2.
- **Zero-wait memory:** ack in the first BUSY cycle gives a 3-cycle transaction (IDLE → BUSY → DONE).
- **Throughput:** at most one transaction in flight.
- **Back-to-back requests:** a new request can be accepted at the earliest in the IDLE cycle after DONE.
- **Simultaneous events:** ack and timeout expiry in the same cycle means ack wins.

## Configuration
- Macro: `LSU_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter equals `TIMEOUT_CYCLES - 1` with no ack:
    - go to DONE with the error flag set;
    - drop `dmem_req_o` at that edge;
    - in DONE, `err_o` = 1 and `wb_valid_o` = 0.
- **Undefined:**
  - No counter; BUSY waits indefinitely for ack.
  - `err_o` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset: `rst_i` high for 2 cycles mid-BUSY → `dmem_req_o` = 0 after the edge, state IDLE, later ack yields no `wb_valid_o`.
- Load, zero-wait: addr 0x0010, `rd` = 3, ack with rdata 0xBEEF in first BUSY cycle → `wb_valid_o` pulse in cycle 2, `wb_rd_addr_o` = 3, `wb_data_o` = 0xBEEF.
- Store, 4-cycle wait: addr 0x0020, wdata 0x1234, ack after 4 BUSY cycles → `dmem_we_o` = 1 and addr/data stable for all 4 cycles, no `wb_valid_o`, `stall_o` high throughout BUSY.
- Back-to-back: `req_valid_i` held high across two requests → second accepted only in the IDLE cycle after DONE, and `req_valid_i` in DONE is not captured.
- Spurious ack: `dmem_ack_i` high in IDLE and DONE → no state change, no write-back.
- `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, no ack → `dmem_req_o` high for exactly 8 cycles, then `err_o` pulse, `wb_valid_o` = 0, IDLE. Repeat with ack on cycle 8 → normal completion, `err_o` = 0.
